// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit uio pad bus between NREQ requesters with bounded bursts.
// Optional macro UIO_ARB_TURNAROUND_EN inserts one undriven TURN cycle between owners.
module uio_bus_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     last,
  input  logic [NREQ*8-1:0]   req_out,
  input  logic [NREQ*8-1:0]   req_oe,
  output logic [NREQ-1:0]     gnt,
  output logic                busy,
  output logic [7:0]          uio_out,
  output logic [7:0]          uio_oe,
  input  logic [7:0]          uio_in,
  output logic [7:0]          rd_data
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef UIO_ARB_TURNAROUND_EN
    S_GRANT,
    S_TURN
`else
    S_GRANT
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic            rel;
  logic            do_arb;

  // Rotating priority search starting at the rr pointer, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IW'((32'(rr_q) + i) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign rel = last[owner_q] | ~req[owner_q] | (count_q == CW'(MAX_BURST)) | ~ena;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      count_q <= '0;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      count_q <= count_d;
      rd_data <= uio_in;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    count_d = count_q;
    do_arb  = 1'b0;
    case (state_q)
      S_IDLE: do_arb = 1'b1;
      S_GRANT: begin
        if (rel) begin
          gnt_d   = '0;
          count_d = '0;
`ifdef UIO_ARB_TURNAROUND_EN
          state_d = S_TURN;
`else
          state_d = S_IDLE;
          do_arb  = 1'b1;
`endif
        end else begin
          count_d = count_q + 1'b1;
        end
      end
`ifdef UIO_ARB_TURNAROUND_EN
      S_TURN: do_arb = 1'b1;
`endif
      default: state_d = S_IDLE;
    endcase

    // Release and new grant can share one edge, giving a zero-gap handoff.
    if (do_arb) begin
      state_d = S_IDLE;
      gnt_d   = '0;
      if (ena && win_found) begin
        state_d        = S_GRANT;
        gnt_d[win_idx] = 1'b1;
        owner_d        = win_idx;
        rr_d           = IW'((32'(win_idx) + 1) % NREQ);
        count_d        = CW'(1);
      end
    end
  end

  always_comb begin
    busy    = (state_q == S_GRANT);
    uio_out = '0;
    uio_oe  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      uio_out = uio_out | (req_out[8*i +: 8] & {8{gnt_q[i]}});
      uio_oe  = uio_oe  | (req_oe[8*i +: 8]  & {8{gnt_q[i]}});
    end
  end

  assign gnt = gnt_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter: directed scenarios plus randomized traffic against a cycle model.
module tb_uio_bus_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 8;
`ifdef UIO_ARB_TURNAROUND_EN
  localparam bit TURN_EN = 1'b1;
`else
  localparam bit TURN_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ena = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   last = '0;
  logic [N*8-1:0] req_out = '0;
  logic [N*8-1:0] req_oe = '0;
  logic [N-1:0]   gnt;
  logic           busy;
  logic [7:0]     uio_out;
  logic [7:0]     uio_oe;
  logic [7:0]     uio_in = '0;
  logic [7:0]     rd_data;

  int errors = 0;
  int checks = 0;

  // Reference model state: owner index (-1 = bus free), beats granted so far, next priority, gap pending.
  int       m_owner = -1;
  int       m_cnt = 0;
  int       m_rr = 0;
  bit       m_turn = 1'b0;
  logic [7:0] m_rd = '0;

  uio_bus_arbiter #(.NREQ(N), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .last(last),
    .req_out(req_out), .req_oe(req_oe), .gnt(gnt), .busy(busy),
    .uio_out(uio_out), .uio_oe(uio_oe), .uio_in(uio_in), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic model_pick();
    bit found = 1'b0;
    if (ena && req != '0) begin
      for (int k = 0; k < N; k++) begin
        int idx = (m_rr + k) % N;
        if (!found && req[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_cnt   = 1;
          m_rr    = (idx + 1) % N;
        end
      end
    end
  endtask

  // Advance one clock: model consumes the inputs present at the edge, then outputs settle.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_rr = 0; m_turn = 1'b0; m_rd = '0;
    end else begin
      m_rd = uio_in;
      if (m_owner >= 0) begin
        if (last[m_owner] || !req[m_owner] || m_cnt == MAXB || !ena) begin
          m_owner = -1;
          if (TURN_EN) m_turn = 1'b1;
          else model_pick();
        end else begin
          m_cnt++;
        end
      end else if (m_turn) begin
        m_turn = 1'b0;
        model_pick();
      end else begin
        model_pick();
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; last = '0; ena = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; last = '0; ena = 1'b1;
    req_out = 32'h5A5A_5A5A; req_oe = '1; uio_in = 8'h77;
    tick(); tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b expected 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (uio_oe !== 8'h00) begin errors++; $display("FAIL reset_oe got %h expected 00", uio_oe); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_out got %h expected 00", uio_out); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd got %h expected 00", rd_data); end
  endtask

  task automatic test_single_burst();
    do_reset();
    req_out = {8'h11, 8'h22, 8'h33, 8'hA5};
    req_oe  = {8'h0F, 8'hF0, 8'h3C, 8'hFF};
    tick();
    req = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt beat %0d got %b expected 0001", c, gnt); end
      checks++; if (uio_out !== 8'hA5) begin errors++; $display("FAIL single_out beat %0d got %h expected a5", c, uio_out); end
      checks++; if (uio_oe !== 8'hFF) begin errors++; $display("FAIL single_oe beat %0d got %h expected ff", c, uio_oe); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy beat %0d got %b expected 1", c, busy); end
    end
    last = 4'b0001; req = 4'b0000;
    tick();
    last = '0;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_release got %b expected 0000", gnt); end
    checks++; if (uio_oe !== 8'h00) begin errors++; $display("FAIL single_release_oe got %h expected 00", uio_oe); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL single_release_out got %h expected 00", uio_out); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    do_reset();
    req = '1; last = '1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp = '0; exp[i % N] = 1'b1;
      checks++; if (gnt !== exp) begin errors++; $display("FAIL rr_order slot %0d got %b expected %b", i, gnt, exp); end
      if (TURN_EN && i < 4) begin
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_gap slot %0d got %b expected 0000", i, gnt); end
      end
    end
    req = '0; last = '0;
    tick(); tick();
  endtask

  task automatic test_max_burst();
    do_reset();
    req = 4'b0010; last = '0;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL burst_beat 1 got %b expected 0010", gnt); end
    req = 4'b0011;
    for (int c = 2; c <= MAXB; c++) begin
      tick();
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL burst_beat %0d got %b expected 0010", c, gnt); end
    end
    tick();
    if (TURN_EN) begin
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL burst_gap got %b expected 0000", gnt); end
      tick();
    end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL burst_next got %b expected 0001", gnt); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_ena_drop();
    do_reset();
    req = 4'b0100; req_oe = {8'h0F, 8'hF0, 8'h3C, 8'hFF};
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL ena_beat %0d got %b expected 0100", c, gnt); end
    end
    ena = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL ena_release got %b expected 0000", gnt); end
    checks++; if (uio_oe !== 8'h00) begin errors++; $display("FAIL ena_release_oe got %h expected 00", uio_oe); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL ena_hold %0d got %b expected 0000", c, gnt); end
    end
    ena = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL ena_resume got %b expected 0100", gnt); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_mid_reset();
    req = '1; last = '0; ena = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL midrst_gnt got %b expected 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", busy); end
    rst = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL midrst_first got %b expected 0001", gnt); end
    uio_in = 8'h00;
    tick();
    uio_in = 8'h3C;
    #1;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rd_early got %h expected 00", rd_data); end
    tick();
    checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL rd_latency got %h expected 3c", rd_data); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    logic [7:0]   eo, ee;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      last    = '0;
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) last[b] = 1'b1;
      ena     = ($urandom_range(0, 15) != 0);
      rst     = ($urandom_range(0, 199) == 0);
      req_out = 32'($urandom);
      req_oe  = 32'($urandom);
      uio_in  = 8'($urandom);
      tick();
      eg = '0; eo = '0; ee = '0;
      if (m_owner >= 0) begin
        eg[m_owner] = 1'b1;
        eo = req_out[8*m_owner +: 8];
        ee = req_oe[8*m_owner +: 8];
      end
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rand_gnt cyc %0d got %b expected %b", cyc, gnt, eg); end
      checks++; if (busy !== (m_owner >= 0)) begin errors++; $display("FAIL rand_busy cyc %0d got %b expected %b", cyc, busy, (m_owner >= 0)); end
      checks++; if (uio_out !== eo) begin errors++; $display("FAIL rand_out cyc %0d got %h expected %h", cyc, uio_out, eo); end
      checks++; if (uio_oe !== ee) begin errors++; $display("FAIL rand_oe cyc %0d got %h expected %h", cyc, uio_oe, ee); end
      checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL rand_rd cyc %0d got %h expected %h", cyc, rd_data, m_rd); end
    end
    rst = 1'b0; req = '0; last = '0; ena = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_max_burst();
    test_ena_drop();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
